hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/hazard_perf_ctr.sv | 21 ++
 rtl/hazard_unit.sv | 99 +++++++++
 tb/tb_hazard_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types and hazard-control encodings.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic halted;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_IDLE = '0;

  localparam hazard_ctrl_t CTRL_HALT = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, exmem_flush: 1'b0, memwb_en: 1'b0, halted: 1'b1};

  localparam hazard_ctrl_t CTRL_NORMAL = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, halted: 1'b0};

  // Squash the two younger stages; the redirected PC is loaded this cycle.
  localparam hazard_ctrl_t CTRL_REDIRECT = '{
    pc_en: 1'b1, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, halted: 1'b0};

  // Hold PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
  localparam hazard_ctrl_t CTRL_BUBBLE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1, idex_flush: 1'b1,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, halted: 1'b0};

  function automatic logic load_use_hazard(
    input logic     dren,
    input regbits_t wsel,
    input regbits_t rs,
    input regbits_t rt
  );
    return dren && (wsel != '0) && ((wsel == rs) || (wsel == rt));
  endfunction

endpackage

// File: rtl/hazard_perf_ctr.sv
// rtl/hazard_perf_ctr.sv - saturating performance event counter.
module hazard_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush/halt control with perf counters.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  regbits_t         rs_id,
  input  regbits_t         rt_id,
  input  logic             dREN_ex,
  input  regbits_t         wsel_ex,
  input  logic             brTaken_ex,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             halt_wb,
  output logic             pcEN,
  output logic             ifidEN,
  output logic             ifidFlush,
  output logic             idexEN,
  output logic             idexFlush,
  output logic             exmemEN,
  output logic             exmemFlush,
  output logic             memwbEN,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  hazard_state_t state_q, state_d;
  hazard_ctrl_t  ctrl;
  logic          stall_inc, flush_inc;
  logic          dmem_pending, load_use;

  assign dmem_pending = dREN_mem || dWEN_mem;
  assign load_use     = load_use_hazard(dREN_ex, wsel_ex, rs_id, rt_id);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are gated by nRST so every enable drops the moment reset asserts.
  always_comb begin
    ctrl      = CTRL_IDLE;
    state_d   = state_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (nRST) begin
      if ((state_q == HALT) || halt_wb) begin
        ctrl    = CTRL_HALT;
        state_d = HALT;
      end else if (dmem_pending && !dhit) begin
        state_d = DWAIT;
      end else begin
        state_d = RUN;
        if (brTaken_ex) begin
          ctrl      = CTRL_REDIRECT;
          flush_inc = 1'b1;
        end else if (load_use || !ihit) begin
          ctrl      = CTRL_BUBBLE;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_NORMAL;
        end
      end
    end
  end

  assign pcEN       = ctrl.pc_en;
  assign ifidEN     = ctrl.ifid_en;
  assign ifidFlush  = ctrl.ifid_flush;
  assign idexEN     = ctrl.idex_en;
  assign idexFlush  = ctrl.idex_flush;
  assign exmemEN    = ctrl.exmem_en;
  assign exmemFlush = ctrl.exmem_flush;
  assign memwbEN    = ctrl.memwb_en;
  assign halted     = ctrl.halted;

  hazard_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stallCnt)
  );

  hazard_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .count (flushCnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed checks of hazard_unit against a rule model.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, dREN_ex, brTaken_ex, dREN_mem, dWEN_mem, halt_wb;
  logic [4:0] rs_id, rt_id, wsel_ex;

  logic        pc_a, ifen_a, iffl_a, iden_a, idfl_a, emen_a, emfl_a, mwen_a, halt_a;
  logic        pc_b, ifen_b, iffl_b, iden_b, idfl_b, emen_b, emfl_b, mwen_b, halt_b;
  logic [31:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  int n_cmp = 0;
  int n_mis = 0;

  bit          halt_m;
  longint      stall_m, flush_m, stall4_m, flush4_m;

  always #5 CLK = ~CLK;

  hazard_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .rs_id(rs_id), .rt_id(rt_id),
    .dREN_ex(dREN_ex), .wsel_ex(wsel_ex), .brTaken_ex(brTaken_ex), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .halt_wb(halt_wb), .pcEN(pc_a), .ifidEN(ifen_a), .ifidFlush(iffl_a),
    .idexEN(iden_a), .idexFlush(idfl_a), .exmemEN(emen_a), .exmemFlush(emfl_a),
    .memwbEN(mwen_a), .halted(halt_a), .stallCnt(stall_a), .flushCnt(flush_a)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .rs_id(rs_id), .rt_id(rt_id),
    .dREN_ex(dREN_ex), .wsel_ex(wsel_ex), .brTaken_ex(brTaken_ex), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .halt_wb(halt_wb), .pcEN(pc_b), .ifidEN(ifen_b), .ifidFlush(iffl_b),
    .idexEN(iden_b), .idexFlush(idfl_b), .exmemEN(emen_b), .exmemFlush(emfl_b),
    .memwbEN(mwen_b), .halted(halt_b), .stallCnt(stall_b), .flushCnt(flush_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rule classes: 0 reset, 1 halt, 2 dmem-wait, 3 redirect, 4 load-use, 5 imem-wait, 6 normal
  function automatic int rule_now();
    if (!nRST) return 0;
    if (halt_m || halt_wb) return 1;
    if ((dREN_mem || dWEN_mem) && !dhit) return 2;
    if (brTaken_ex) return 3;
    if (dREN_ex && wsel_ex != 0 && (wsel_ex == rs_id || wsel_ex == rt_id)) return 4;
    if (!ihit) return 5;
    return 6;
  endfunction

  // {pcEN, ifidEN, ifidFlush, idexEN, idexFlush, exmemEN, exmemFlush, memwbEN, halted}
  function automatic logic [8:0] exp_ctrl(input int r);
    case (r)
      1:       return 9'b000000001;
      3:       return 9'b101011010;
      4, 5:    return 9'b000111010;
      6:       return 9'b110101010;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic longint sat_inc(input longint v, input int w);
    longint top = (64'sd1 <<< w) - 1;
    return (v >= top) ? top : v + 1;
  endfunction

  task automatic model_reset();
    halt_m = 0; stall_m = 0; flush_m = 0; stall4_m = 0; flush4_m = 0;
  endtask

  // Called at posedge+1: check mid-cycle, then advance model at the next edge.
  task automatic cycle();
    int r;
    logic [8:0] e;
    #3;
    r = rule_now();
    e = exp_ctrl(r);
    check("ctrl32", {pc_a, ifen_a, iffl_a, iden_a, idfl_a, emen_a, emfl_a, mwen_a, halt_a}, e);
    check("ctrl4",  {pc_b, ifen_b, iffl_b, iden_b, idfl_b, emen_b, emfl_b, mwen_b, halt_b}, e);
    check("stall32", stall_a, stall_m);
    check("flush32", flush_a, flush_m);
    check("stall4", stall_b, stall4_m);
    check("flush4", flush_b, flush4_m);
    @(posedge CLK);
    if (!nRST) model_reset();
    else begin
      if (r == 1) halt_m = 1;
      if (r == 3) begin flush_m = sat_inc(flush_m, 32); flush4_m = sat_inc(flush4_m, 4); end
      if (r == 4 || r == 5) begin stall_m = sat_inc(stall_m, 32); stall4_m = sat_inc(stall4_m, 4); end
    end
    #1;
  endtask

  // Asynchronous reset pulse between edges; effect must be visible before any clock edge.
  task automatic pulse_reset();
    #2 nRST = 0;
    #1;
    check("rst_ctrl", {pc_a, ifen_a, iffl_a, iden_a, idfl_a, emen_a, emfl_a, mwen_a, halt_a}, 9'd0);
    check("rst_stall", stall_a, 0);
    check("rst_flush", flush_a, 0);
    model_reset();
    @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic idle_inputs();
    ihit = 1; dhit = 0; rs_id = 0; rt_id = 0; dREN_ex = 0; wsel_ex = 0;
    brTaken_ex = 0; dREN_mem = 0; dWEN_mem = 0; halt_wb = 0;
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    model_reset();
    @(posedge CLK); #1;
    cycle(); cycle();
    nRST = 1;
    cycle();

    // load-use one-cycle bubble
    dREN_ex = 1; wsel_ex = 5; rs_id = 5; rt_id = 9;
    cycle();
    dREN_ex = 0;
    cycle();
    check("lu_stallcnt", stall_a, 1);
    check("lu_after_pc", pc_a, 1);

    // redirect beats load-use
    pulse_reset();
    dREN_ex = 1; wsel_ex = 5; rs_id = 5; brTaken_ex = 1;
    cycle();
    idle_inputs();
    check("br_flushcnt", flush_a, 1);
    check("br_stallcnt", stall_a, 0);

    // r0 destination never stalls
    dREN_ex = 1; wsel_ex = 0; rs_id = 0; rt_id = 0;
    cycle();
    idle_inputs();

    // dmem wait for 3 cycles, released by dhit
    dWEN_mem = 1; dhit = 0;
    repeat (3) cycle();
    check("dw_state", dut.state_q, 1);
    dhit = 1;
    cycle();
    check("dw_back_run", dut.state_q, 0);
    idle_inputs();
    cycle();

    // halt is sticky; reset in HALT recovers asynchronously
    halt_wb = 1;
    cycle();
    halt_wb = 0; brTaken_ex = 1;
    repeat (3) cycle();
    idle_inputs();
    pulse_reset();
    check("halt_cleared", halt_a, 0);
    cycle();

    // saturation of the 4-bit counters
    ihit = 0;
    repeat (20) cycle();
    check("sat4", stall_b, 15);
    check("nosat32", stall_a, 20);
    idle_inputs();

    // reset mid-DWAIT
    dREN_mem = 1; dhit = 0;
    repeat (2) cycle();
    pulse_reset();
    idle_inputs();
    cycle();

    for (int i = 0; i < 2000; i++) begin
      ihit       = ($urandom_range(3) != 0);
      dhit       = $urandom_range(1);
      rs_id      = 5'($urandom_range(3));
      rt_id      = 5'($urandom_range(3));
      wsel_ex    = 5'($urandom_range(3));
      dREN_ex    = $urandom_range(1);
      brTaken_ex = ($urandom_range(4) == 0);
      dREN_mem   = ($urandom_range(3) == 0);
      dWEN_mem   = ($urandom_range(5) == 0);
      halt_wb    = ($urandom_range(299) == 0);
      if ($urandom_range(149) == 0) pulse_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
